// File: rtl/bird_column.sv
// Vertical bird-position engine: a single column of ROWS lights with exactly one lit,
// driven by flap impulses, gravity ticks, edge clamp/crash handling and obstacle hits.
module bird_column #(
    parameter int ROWS       = 8,
    parameter int START_ROW  = 4,
    parameter int FLAP_RISE  = 2,
    parameter int FALL_DELAY = 2,
    parameter int CLAMP      = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick,
    input  logic                    pause,
    input  logic                    flap,
    input  logic                    hit,
    output logic [ROWS-1:0]         light,
    output logic [$clog2(ROWS)-1:0] row,
    output logic                    alive,
    output logic                    crashed
);

    localparam int RW     = $clog2(ROWS);
    localparam int RISE_W = (FLAP_RISE  > 1) ? $clog2(FLAP_RISE + 1)  : 1;
    localparam int FALL_W = (FALL_DELAY > 1) ? $clog2(FALL_DELAY + 1) : 1;

    localparam logic [RW-1:0]     TOP_ROW   = RW'(ROWS - 1);
    localparam logic [RW-1:0]     INIT_ROW  = RW'(START_ROW);
    localparam logic [RISE_W-1:0] RISE_LOAD = RISE_W'(FLAP_RISE - 1);
    localparam logic [FALL_W-1:0] FALL_LAST = FALL_W'(FALL_DELAY - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FLY     = 2'd1,
        CRASHED = 2'd2
    } state_t;

    state_t             state_r, state_n;
    logic [RW-1:0]      row_r, row_n;
    logic [ROWS-1:0]    light_r;
    logic               alive_r, crashed_r;
    logic [RISE_W-1:0]  rise_cnt_r, rise_cnt_n;
    logic [FALL_W-1:0]  fall_cnt_r, fall_cnt_n;
    logic               flap_pend_r, flap_pend_n;
    logic               flap_q_r;
    logic               flap_edge_s, flap_req_s;
    logic               step_s, move_up_s, move_dn_s;

    function automatic logic [ROWS-1:0] onehot(input logic [RW-1:0] r);
        logic [ROWS-1:0] v;
        v = {{(ROWS-1){1'b0}}, 1'b1} << r;
        return v;
    endfunction

    // Next-state logic: game phase, row motion, rise/fall counters and pending flap.
    always_comb begin
        flap_edge_s = flap & ~flap_q_r;
        flap_req_s  = flap_pend_r | flap_edge_s;
        state_n     = state_r;
        row_n       = row_r;
        rise_cnt_n  = rise_cnt_r;
        fall_cnt_n  = fall_cnt_r;
        flap_pend_n = flap_pend_r;
        step_s      = 1'b0;
        move_up_s   = 1'b0;
        move_dn_s   = 1'b0;

        case (state_r)
            IDLE: begin
                if (flap_edge_s & ~pause) begin
                    state_n     = FLY;
                    flap_pend_n = 1'b1;
                    step_s      = tick;
                end else begin
                    state_n = IDLE;
                end
            end
            FLY: begin
                if (pause) begin
                    state_n = FLY;
                end else if (hit) begin
                    state_n = CRASHED;
                end else if (tick) begin
                    step_s = 1'b1;
                end else if (flap_edge_s) begin
                    flap_pend_n = 1'b1;
                end else begin
                    flap_pend_n = flap_pend_r;
                end
            end
            CRASHED: begin
                state_n = CRASHED;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // A tick picks one motion; edge handling below decides clamp vs crash.
        if (step_s) begin
            if (flap_req_s) begin
                move_up_s   = 1'b1;
                rise_cnt_n  = RISE_LOAD;
                fall_cnt_n  = {FALL_W{1'b0}};
                flap_pend_n = 1'b0;
            end else if (rise_cnt_r != {RISE_W{1'b0}}) begin
                move_up_s  = 1'b1;
                rise_cnt_n = rise_cnt_r - RISE_W'(1);
            end else if (fall_cnt_r == FALL_LAST) begin
                move_dn_s  = 1'b1;
                fall_cnt_n = {FALL_W{1'b0}};
            end else begin
                fall_cnt_n = fall_cnt_r + FALL_W'(1);
            end

            if (move_up_s) begin
                if (row_r == TOP_ROW) begin
                    if (CLAMP != 0) begin
                        rise_cnt_n = {RISE_W{1'b0}};
                    end else begin
                        state_n = CRASHED;
                    end
                end else begin
                    row_n = row_r + RW'(1);
                end
            end else if (move_dn_s) begin
                if (row_r == {RW{1'b0}}) begin
                    if (CLAMP != 0) begin
                        row_n = row_r;
                    end else begin
                        state_n = CRASHED;
                    end
                end else begin
                    row_n = row_r - RW'(1);
                end
            end else begin
                row_n = row_r;
            end
        end else begin
            row_n = row_r;
        end
    end

    // State and registered outputs; light/alive/crashed are derived from next-state values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            row_r       <= INIT_ROW;
            light_r     <= onehot(INIT_ROW);
            alive_r     <= 1'b1;
            crashed_r   <= 1'b0;
            rise_cnt_r  <= {RISE_W{1'b0}};
            fall_cnt_r  <= {FALL_W{1'b0}};
            flap_pend_r <= 1'b0;
            flap_q_r    <= 1'b0;
        end else begin
            state_r     <= state_n;
            row_r       <= row_n;
            light_r     <= onehot(row_n);
            alive_r     <= (state_n != CRASHED);
            crashed_r   <= (state_n == CRASHED);
            rise_cnt_r  <= rise_cnt_n;
            fall_cnt_r  <= fall_cnt_n;
            flap_pend_r <= flap_pend_n;
            flap_q_r    <= flap;
        end
    end

    assign light   = light_r;
    assign row     = row_r;
    assign alive   = alive_r;
    assign crashed = crashed_r;

endmodule

// File: tb/tb_bird_column.sv
// Bench for bird_column: a CLAMP=0 and a CLAMP=1 instance share one stimulus stream and
// are checked every cycle against an integer-level model, plus hand-computed expectations.
module tb_bird_column;

    localparam int ROWS  = 8;
    localparam int START = 4;
    localparam int RISE  = 2;
    localparam int FALL  = 2;

    logic clk = 1'b0;
    logic reset = 1'b1, tick = 1'b0, pause = 1'b0, flap = 1'b0, hit = 1'b0;
    logic [7:0] light0, light1;
    logic [2:0] row0, row1;
    logic alive0, alive1, crashed0, crashed1;

    int n_chk = 0;
    int n_fail = 0;
    bit go = 1'b0;

    always #5 clk = ~clk;

    bird_column #(.ROWS(ROWS), .START_ROW(START), .FLAP_RISE(RISE), .FALL_DELAY(FALL), .CLAMP(0)) u_nc (
        .clk(clk), .reset(reset), .tick(tick), .pause(pause), .flap(flap), .hit(hit),
        .light(light0), .row(row0), .alive(alive0), .crashed(crashed0));

    bird_column #(.ROWS(ROWS), .START_ROW(START), .FLAP_RISE(RISE), .FALL_DELAY(FALL), .CLAMP(1)) u_cl (
        .clk(clk), .reset(reset), .tick(tick), .pause(pause), .flap(flap), .hit(hit),
        .light(light1), .row(row1), .alive(alive1), .crashed(crashed1));

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model: index 0 crashes at the edges, index 1 clamps. 0=idle 1=flying 2=crashed.
    int m_st[2], m_row[2], m_rise[2], m_fall[2];
    bit m_pend[2];
    bit m_fq = 1'b0;

    task automatic model_tick(input int i, input bit e);
        int dir, want;
        if (m_pend[i] || e) begin
            dir = 1; m_rise[i] = RISE - 1; m_fall[i] = 0; m_pend[i] = 0;
        end else if (m_rise[i] > 0) begin
            dir = 1; m_rise[i]--;
        end else begin
            m_fall[i]++;
            dir = (m_fall[i] == FALL) ? -1 : 0;
            if (dir != 0) m_fall[i] = 0;
        end
        want = m_row[i] + dir;
        if (want < 0 || want > ROWS - 1) begin
            if (i == 1) begin
                if (dir > 0) m_rise[i] = 0;
            end else begin
                m_st[i] = 2;
            end
        end else begin
            m_row[i] = want;
        end
    endtask

    always @(posedge clk) begin
        bit e;
        e = flap && !m_fq;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_st[i] = 0; m_row[i] = START; m_rise[i] = 0; m_fall[i] = 0; m_pend[i] = 0;
            end else if (m_st[i] == 0) begin
                if (e && !pause) begin
                    m_st[i] = 1; m_pend[i] = 1;
                    if (tick) model_tick(i, e);
                end
            end else if (m_st[i] == 1 && !pause) begin
                if (hit) m_st[i] = 2;
                else if (tick) model_tick(i, e);
                else if (e) m_pend[i] = 1;
            end
        end
        m_fq = reset ? 1'b0 : flap;
    end

    always @(negedge clk) begin
        if (go) begin
            chk("nc_row", int'(row0), m_row[0]);
            chk("nc_light", int'(light0), 1 << m_row[0]);
            chk("nc_alive", int'(alive0), int'(m_st[0] != 2));
            chk("nc_crashed", int'(crashed0), int'(m_st[0] == 2));
            chk("cl_row", int'(row1), m_row[1]);
            chk("cl_light", int'(light1), 1 << m_row[1]);
            chk("cl_alive", int'(alive1), int'(m_st[1] != 2));
            chk("cl_crashed", int'(crashed1), int'(m_st[1] == 2));
        end
    end

    task automatic cyc(input bit t, input bit f, input bit h, input bit p);
        tick = t; flap = f; hit = h; pause = p;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    int seq2[6] = '{5, 6, 6, 5, 5, 4};
    int peak;

    initial begin
        @(negedge clk);
        do_reset();
        go = 1'b1;
        // Reset state and idle ticks (a hit while idle is ignored)
        chk("rst_row", int'(row0), 4);
        chk("rst_light", int'(light0), 8'h10);
        chk("rst_alive", int'(alive0), 1);
        chk("rst_crashed", int'(crashed0), 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, (i == 2), 1'b0);
            chk("idle_row", int'(row0), 4);
            chk("idle_alive", int'(alive0), 1);
        end
        chk("idle_light", int'(light0), 8'h10);

        // Single flap then gravity down to the floor
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            chk("flap_seq_nc", int'(row0), seq2[i]);
            chk("flap_seq_cl", int'(row1), seq2[i]);
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("floor_crashed", int'(crashed0), 1);
        chk("floor_alive", int'(alive0), 0);
        chk("floor_light", int'(light0), 8'h01);
        chk("floor_clamp_row", int'(row1), 0);
        chk("floor_clamp_alive", int'(alive1), 1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            cyc(1'b1, 1'b0, 1'b1, 1'b0);
        end
        chk("frozen_light", int'(light0), 8'h01);
        chk("frozen_crashed", int'(crashed0), 1);
        do_reset();
        chk("rerst_row", int'(row0), 4);
        chk("rerst_alive", int'(alive0), 1);

        // Flap held high: one registered flap
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        peak = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            if (int'(row0) > peak) peak = int'(row0);
        end
        chk("held_peak", peak, 6);
        chk("held_final", int'(row0), 2);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        do_reset();

        // Repeated flaps into the ceiling
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("top_clamp_row", int'(row1), 7);
        chk("top_clamp_light", int'(light1), 8'h80);
        chk("top_clamp_alive", int'(alive1), 1);
        chk("top_crash_row", int'(row0), 7);
        chk("top_crash", int'(crashed0), 1);
        do_reset();

        // Pause freezes motion; a flap during pause is dropped
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("pause_pre_row", int'(row0), 5);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        chk("pause_row", int'(row0), 5);
        chk("pause_alive", int'(alive0), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("resume_rise", int'(row0), 6);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("no_ghost_flap", int'(row0), 6);
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        chk("pause_hit_alive", int'(alive0), 1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk("hit_crashed", int'(crashed0), 1);
        chk("hit_row", int'(row0), 6);
        chk("hit_light", int'(light1), 8'h40);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        go = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bird_column.md
# bird_column

Parametrised vertical bird-position engine for the FlappyBirds LED matrix. It replaces the per-LED on/off cells with a single column of `ROWS` lights, exactly one lit, driven by a registered row counter. The bird rises on flap impulses, falls under gravity at a configurable rate, and either clamps or crashes at the edges. It also accepts an obstacle-hit input from the pipe logic and reports alive/crashed status to the game controller.

## Interface
Parameters:
- `ROWS`, default 8: column height; row 0 = bottom, row `ROWS-1` = top; legal range ≥ 2.
- `START_ROW`, default 4: row loaded on reset; legal range 0..`ROWS-1`.
- `FLAP_RISE`, default 2: rows climbed per flap, one per tick; legal range ≥ 1.
- `FALL_DELAY`, default 2: ticks per one-row fall; legal range ≥ 1.
- `CLAMP`, default 0: 1 = stop at top/bottom edge; 0 = hitting an edge crashes.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `tick` in 1: one-cycle game-step strobe.
- `pause` in 1: freezes all motion and state.
- `flap` in 1: key level, rising-edge detected internally.
- `hit` in 1: obstacle occupies the bird's current row.
- `light` out `ROWS`: one-hot, `light[row]`=1.
- `row` out `$clog2(ROWS)`: current row.
- `alive` out 1: 0 once crashed.
- `crashed` out 1: equals `~alive`, registered.

## Operation
- States: IDLE (waiting for first flap), FLY, CRASHED.
- Flap edge: `flap_edge = flap & ~flap_q`. `flap_q` updates every cycle, including during pause.
- Edges seen while `pause=1` are discarded.
- An edge outside pause sets `flap_pend`. The pending flag is consumed on the next applied tick.
- `flap_req = flap_pend | flap_edge`, so an edge in the same cycle as a tick is applied on that tick.
- IDLE: the row holds at `START_ROW` and ticks are ignored. `flap_edge` moves to FLY with `flap_pend` set. `hit` is ignored.
- FLY, on `tick & ~pause`, the first matching rule applies:
  - `flap_req`: move up 1; `rise_cnt <= FLAP_RISE-1`; `fall_cnt <= 0`; clear `flap_pend`.
  - else `rise_cnt > 0`: move up 1; decrement `rise_cnt`.
  - else: if `fall_cnt == FALL_DELAY-1`, move down 1 and set `fall_cnt <= 0`; otherwise increment `fall_cnt`.
- Edge moves:
  - Moving up from `ROWS-1` or down from 0 with `CLAMP=1`: the row is unchanged and `rise_cnt` clears on a top clamp.
  - The same move with `CLAMP=0`: go to CRASHED with the row unchanged.
- FLY with `hit & ~pause` (no tick needed): go to CRASHED. `hit` takes priority over a same-cycle tick; the row is not updated.
- CRASHED: `row` and `light` freeze, `alive=0`, `crashed=1`. Flap, tick, hit and pause are ignored. Only reset exits.
- Pause in FLY: `row`, `rise_cnt`, `fall_cnt`, `flap_pend` and the state all hold.

## Timing
- All outputs are registered. A tick or hit applied at rising edge k is visible after edge k, i.e. 1-cycle latency.
- Reset, which overrides everything including mid-crash and mid-rise:
  - state=IDLE, `row=START_ROW`, `light` = one-hot(`START_ROW`);
  - `alive=1`, `crashed=0`;
  - `rise_cnt=0`, `fall_cnt=0`, `flap_pend=0`, `flap_q=0`.
- The IDLE→FLY transition takes 1 cycle. The first movement occurs on the first tick at or after the edge, including a tick in the same cycle as the edge.
- `light` is always exactly one-hot and is never all zeros.

## Test plan
All scenarios use ROWS=8, START_ROW=4, FLAP_RISE=2, FALL_DELAY=2.
1. Reset, then 5 ticks with no flap → `row=4`, `light=8'b0001_0000`, `alive=1` throughout.
2. Flap edge, then ticks 1-6 → row sequence 5, 6, 6, 5, 5, 4.
3. Flap held high across 10 ticks → only one flap is registered; the peak row is 6, after which the bird falls.
4. CLAMP=0: flap, then let it fall to row 0 and give the next fall tick → `crashed=1`, `alive=0`, `light=8'b0000_0001`. Further flaps and ticks cause no change. Reset → `row=4`, IDLE.
5. CLAMP=1: same stimulus as scenario 4 → `row` stays 0 and `alive=1`. Flap edges near the top → `row` saturates at 7.
6. Pause plus `hit=1` plus ticks in FLY at row 5 → nothing changes. A flap edge during pause is dropped and does not fire after release. Deassert pause with `hit=1` → `crashed=1` the next cycle, `row=5`.
